// File: rtl/key_event_decoder_pkg.sv
// Shared key-handling constants: FSM encodings, default timing and counter width.
package key_event_decoder_pkg;

  // 3-bit state encodings for the click/long-press decoder FSM
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT2     = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HELD = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRESS1    = ST_PRESS1,
    WAIT2     = ST_WAIT2,
    PRESS2    = ST_PRESS2,
    LONG_HELD = ST_LONG_HELD
  } key_fsm_e;

  // Default timing in 50 MHz clock cycles
  localparam int LONG_CNT_DEFAULT   = 50_000_000;  // 1 s hold for a long press
  localparam int DBL_GAP_DEFAULT    = 15_000_000;  // 300 ms release-to-press gap
  localparam int REPEAT_CNT_DEFAULT = 10_000_000;  // 200 ms auto-repeat period
  localparam int DEBOUNCE_CNT       = 1_000_000;   // 20 ms debounce window

  // One shared counter serves every timed state; 26 bits covers the 1 s hold
  localparam int CNT_W = 26;
  typedef logic [CNT_W-1:0] key_cnt_t;

  // Terminal value of a timer that must last 'count' cycles
  function automatic key_cnt_t term_value(input int count);
    return key_cnt_t'(count - 1);
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Turns debounced key edges into short-press, long-press, auto-repeat and
// double-click pulses, each one clock wide and registered.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEFAULT,
  parameter int DBL_GAP    = DBL_GAP_DEFAULT,
  parameter int REPEAT_CNT = REPEAT_CNT_DEFAULT
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic long_repeat,
  output logic double_click
);

  localparam key_cnt_t LONG_TERM   = term_value(LONG_CNT);
  localparam key_cnt_t GAP_TERM    = term_value(DBL_GAP);
  localparam key_cnt_t REPEAT_TERM = term_value(REPEAT_CNT);

  key_fsm_e state;
  key_fsm_e next_state;
  key_cnt_t cnt;

  logic press_evt;
  logic release_evt;
  logic long_done;
  logic gap_done;
  logic repeat_done;

  logic short_d;
  logic long_d;
  logic repeat_d;
  logic double_d;

  // Key level is only meaningful while key_flag is high
  assign press_evt   = key_flag & ~key_state;
  assign release_evt = key_flag &  key_state;

  // >= so a counter can never run past its terminal value
  assign long_done   = (cnt >= LONG_TERM);
  assign gap_done    = (cnt >= GAP_TERM);
  assign repeat_done = (cnt >= REPEAT_TERM);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a key event always takes priority over a timer expiry
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (press_evt) next_state = PRESS1;
      end
      PRESS1: begin
        if (release_evt)    next_state = WAIT2;
        else if (long_done) next_state = LONG_HELD;
      end
      WAIT2: begin
        if (press_evt)     next_state = PRESS2;
        else if (gap_done) next_state = IDLE;
      end
      PRESS2: begin
        if (release_evt)    next_state = IDLE;
        else if (long_done) next_state = LONG_HELD;
      end
      LONG_HELD: begin
        if (release_evt) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: which pulse the current cycle's decision should produce
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    double_d = 1'b0;
    case (state)
      PRESS1:    long_d   = ~release_evt & long_done;
      WAIT2:     short_d  = ~press_evt & gap_done;
      PRESS2: begin
        double_d = release_evt;
        long_d   = ~release_evt & long_done;
      end
      LONG_HELD: repeat_d = ~release_evt & repeat_done;
      default: ;
    endcase
  end

  // Shared timer: cleared on every state change, wraps in LONG_HELD for auto-repeat
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (next_state != state || state == IDLE) begin
      cnt <= '0;
    end else if (state == LONG_HELD && repeat_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + key_cnt_t'(1);
    end
  end

  // Registered one-cycle output pulses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      long_repeat  <= 1'b0;
      double_click <= 1'b0;
    end else begin
      short_press  <= short_d;
      long_press   <= long_d;
      long_repeat  <= repeat_d;
      double_click <= double_d;
    end
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CNT, default 50_000_000, hold time in Clk cycles for a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_GAP, default 15_000_000, maximum release-to-press gap in Clk cycles for a double click (300 ms).
REQ-003 Parameter REPEAT_CNT, default 10_000_000, auto-repeat period in Clk cycles while a long press is held (200 ms).
REQ-004 Clk  input  1  system clock, 50 MHz; single clock domain.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 key_flag  input  1  one-cycle pulse from the debounce stage on each confirmed key edge.
REQ-007 key_state  input  1  debounced key level, 0 = pressed, 1 = released; sampled only when key_flag = 1.
REQ-008 short_press  output  1  one-cycle pulse: single press-release with no second press within DBL_GAP.
REQ-009 long_press  output  1  one-cycle pulse: key held LONG_CNT cycles.
REQ-010 long_repeat  output  1  one-cycle pulse every REPEAT_CNT cycles while still held after long_press.
REQ-011 double_click  output  1  one-cycle pulse: second release of a double click.

Function
REQ-012 Event definitions: press = key_flag & ~key_state; release = key_flag & key_state.
REQ-013 FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD; one shared counter cnt, 26 bits, cleared on every state change.
REQ-014 IDLE: press -> PRESS1; release ignored.
REQ-015 PRESS1: cnt increments each cycle; release -> WAIT2; cnt = LONG_CNT-1 with no release -> LONG_HELD and pulse long_press.
REQ-016 WAIT2: cnt increments; press -> PRESS2; cnt = DBL_GAP-1 with no press -> IDLE and pulse short_press.
REQ-017 PRESS2: cnt increments; release -> IDLE and pulse double_click; cnt = LONG_CNT-1 -> LONG_HELD and pulse long_press; the double click is discarded.
REQ-018 LONG_HELD: cnt increments and wraps to 0 at REPEAT_CNT-1, pulsing long_repeat at each wrap; release -> IDLE, with no pulse issued.
REQ-019 Simultaneous events: a key_flag event wins over a same-cycle counter terminal condition; for example, release at cnt = LONG_CNT-1 in PRESS1 goes to WAIT2 with no long_press.
REQ-020 Events that do not match the state are ignored with no state change: press in PRESS1/PRESS2/LONG_HELD, release in IDLE/WAIT2.
REQ-021 All outputs SHALL be registered and asserted for exactly one Clk cycle, in the cycle after the deciding edge or terminal count is sampled.
REQ-022 At most one output SHALL be high in any cycle.
REQ-023 Counter comparisons use >= terminal value, so a counter can never run past the terminal value.

Reset
REQ-024 Reset_n low SHALL asynchronously force state to IDLE, cnt to 0, and all four outputs to 0.
REQ-025 A reset mid-sequence SHALL emit no pulse; after reset the first valid event is a press.

Structure
REQ-026 State encodings (3-bit localparams) and default timing constants SHALL live in the shared key package/include, together with the debounce constant (1_000_000).
REQ-027 The block SHALL be a single module with no sub-module; the only sequential elements are the FSM, cnt, and output registers.

Verification (sim parameters LONG_CNT=100, DBL_GAP=40, REPEAT_CNT=20)
REQ-028 Press, release after 30 cycles, no further input -> one short_press, 41 cycles after the release pulse; no other output.
REQ-029 Press, release at 30, press 20 cycles later, release 10 later -> one double_click, one cycle after the second release; no short_press.
REQ-030 Press held 165 cycles -> long_press 101 cycles after the press, long_repeat at +20, +40 and +60 after that, and no pulse on release.
REQ-031 Release pulse coincides with cnt = 99 in PRESS1 -> no long_press; FSM in WAIT2; short_press follows the gap timeout.
REQ-032 Reset_n asserted during WAIT2 at cnt = 39 -> all outputs 0, state IDLE, no short_press after reset is released.
REQ-033 Spurious release in IDLE, and a duplicate press in PRESS1 -> no output and no state change; a subsequent normal press-release yields exactly one short_press.
